// File: rtl/ldtu_out_fifo.sv
// Output word buffer between the LiteDTU control unit and the serializer.
// Early full flag absorbs the control unit's one-cycle registered write; reads on empty return an idle word.
module ldtu_out_fifo #(
    parameter int          Nbits_32       = 32,
    parameter int          FifoDepth_buff = 64,
    parameter int          bits_ptr       = 6,
    parameter logic [31:0] IdlePattern    = 32'hEAAAAAAA
) (
    input  logic                CLK,
    input  logic                rst_b,
    input  logic                write_signal,
    input  logic [Nbits_32-1:0] DATA_from_CU,
    input  logic                read_signal,
    output logic                full,
    output logic                empty,
    output logic [Nbits_32-1:0] DATA_out,
    output logic                data_valid,
    output logic [bits_ptr:0]   occupancy,
    output logic                overflow,
    output logic                underrun
);

    localparam logic [bits_ptr:0] DEPTH_C   = (bits_ptr + 1)'(FifoDepth_buff);
    localparam logic [bits_ptr:0] ALMOST_C  = (bits_ptr + 1)'(FifoDepth_buff - 1);
    localparam logic [Nbits_32-1:0] IDLE_C  = Nbits_32'(IdlePattern);

    logic [Nbits_32-1:0] mem [FifoDepth_buff];

    logic [bits_ptr-1:0] wr_ptr_q, wr_ptr_d;
    logic [bits_ptr-1:0] rd_ptr_q, rd_ptr_d;
    logic [bits_ptr:0]   occ_q, occ_d;
    logic [Nbits_32-1:0] dout_q, dout_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;
    logic                udr_q, udr_d;

    logic wr_accept;
    logic rd_accept;

    // Both accept decisions look at the pre-read occupancy, so a full FIFO drops a write even when read in the same cycle.
    assign wr_accept = write_signal && (occ_q < DEPTH_C);
    assign rd_accept = read_signal && (occ_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        udr_d    = udr_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (write_signal) begin
            ovf_d = 1'b1;
        end

        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem[rd_ptr_q];
            valid_d  = 1'b1;
        end else if (read_signal) begin
            dout_d = IDLE_C;
            udr_d  = 1'b1;
        end

        case ({wr_accept, rd_accept})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            dout_q   <= IDLE_C;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udr_q    <= udr_d;
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= DATA_from_CU;
        end
    end

    assign full       = (occ_q >= ALMOST_C);
    assign empty      = (occ_q == '0);
    assign occupancy  = occ_q;
    assign DATA_out   = dout_q;
    assign data_valid = valid_q;
    assign overflow   = ovf_q;
    assign underrun   = udr_q;

endmodule

// File: tb/tb_ldtu_out_fifo.sv
// Scoreboard bench for ldtu_out_fifo: a queue model predicts every output after each clock.
module tb_ldtu_out_fifo;

    localparam int          DEPTH = 64;
    localparam logic [31:0] IDLE  = 32'hEAAAAAAA;

    logic        CLK = 1'b0;
    logic        rst_b = 1'b0;
    logic        write_signal = 1'b0;
    logic [31:0] DATA_from_CU = '0;
    logic        read_signal = 1'b0;
    logic        full, empty, data_valid, overflow, underrun;
    logic [31:0] DATA_out;
    logic [6:0]  occupancy;

    ldtu_out_fifo dut (
        .CLK          (CLK),
        .rst_b        (rst_b),
        .write_signal (write_signal),
        .DATA_from_CU (DATA_from_CU),
        .read_signal  (read_signal),
        .full         (full),
        .empty        (empty),
        .DATA_out     (DATA_out),
        .data_valid   (data_valid),
        .occupancy    (occupancy),
        .overflow     (overflow),
        .underrun     (underrun)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb_q[$];
    logic [31:0] m_dout = IDLE;
    logic        m_valid = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_udr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("dout",  DATA_out, m_dout);
        check_eq("valid", {31'd0, data_valid}, {31'd0, m_valid});
        check_eq("occ",   {25'd0, occupancy}, sb_q.size());
        check_eq("full",  {31'd0, full},  {31'd0, (sb_q.size() >= DEPTH - 1)});
        check_eq("empty", {31'd0, empty}, {31'd0, (sb_q.size() == 0)});
        check_eq("ovf",   {31'd0, overflow}, {31'd0, m_ovf});
        check_eq("udr",   {31'd0, underrun}, {31'd0, m_udr});
    endtask

    // One clock: drive the strobes, update the model, compare after the edge.
    task automatic step(input bit wr, input logic [31:0] d, input bit rd);
        int pre;
        write_signal = wr;
        DATA_from_CU = d;
        read_signal  = rd;
        pre     = sb_q.size();
        m_valid = 1'b0;
        if (rd) begin
            if (pre > 0) begin
                m_dout  = sb_q.pop_front();
                m_valid = 1'b1;
            end else begin
                m_dout = IDLE;
                m_udr  = 1'b1;
            end
        end
        if (wr) begin
            if (pre < DEPTH) sb_q.push_back(d);
            else             m_ovf = 1'b1;
        end
        @(posedge CLK);
        #1;
        if (wr || rd)
            $display("txn wr=%0b din=%08h rd=%0b dout=%08h valid=%0b occ=%0d", wr, d, rd, DATA_out, data_valid, occupancy);
        check_all();
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_dout  = IDLE;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udr   = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #12;
        check_all();
        @(negedge CLK);
        rst_b = 1'b1;

        // Read on empty returns idle and sets underrun
        step(0, '0, 1);
        step(0, '0, 0);

        // Three words in, three out, in order
        step(1, 32'h11111111, 0);
        step(1, 32'h22222222, 0);
        step(1, 32'h33333333, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1);
        step(0, '0, 0);

        // Fill to 64, drop the 65th, drain everything
        for (int i = 0; i < 64; i++) step(1, 32'hA5000000 + i, 0);
        step(1, 32'hDEADBEEF, 0);
        for (int i = 0; i < 64; i++) step(0, '0, 1);
        step(0, '0, 0);

        // Full FIFO with simultaneous read and write: write dropped
        for (int i = 0; i < 64; i++) step(1, 32'hB6000000 + i, 0);
        step(1, 32'hBADBAD00, 1);
        for (int i = 0; i < 63; i++) step(0, '0, 1);

        // Steady state at 10 entries, pointers wrap under concurrent traffic
        for (int i = 0; i < 10; i++) step(1, 32'hC0000000 + i, 0);
        for (int i = 0; i < 100; i++) step(1, 32'hC1000000 + i, 1);
        for (int i = 0; i < 10; i++) step(0, '0, 1);

        // No fall-through on an empty FIFO
        step(1, 32'hD0000001, 1);
        step(0, '0, 1);
        step(0, '0, 0);

        // Asynchronous reset mid-cycle with 20 words stored
        for (int i = 0; i < 20; i++) step(1, 32'hE0000000 + i, 0);
        write_signal = 1'b0;
        read_signal  = 1'b0;
        #2;
        rst_b = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge CLK);
        rst_b = 1'b1;
        step(0, '0, 1);
        step(0, '0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
